// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   state_t : access FSM states
//   ADDR_W  : default data-memory address width (bits)
//   BYTE_W  : default data-memory word width (bits)
package mem_access_unit_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a datapath and a byte-wide data memory.
// Byte accesses use one memory cycle. Wide (two-byte) accesses use two
// cycles, little-endian: the low byte is at addr and the high byte at addr+1.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for req_in; request fields latched on accept
// ACC_LO | memory cycle at addr (low byte)
// ACC_HI | memory cycle at addr+1 (high byte, wide only)
// DONE   | one-cycle done_out pulse, rdata_out updated
//
// Ports:
//   CLK, RESET      : clock, synchronous active-high reset
//   req_in          : access request, sampled only in IDLE
//   write_in        : 1 = store, 0 = load
//   wide_in         : 1 = 16-bit access, 0 = 8-bit access
//   addr_in         : base byte address
//   wdata_in        : store data ([7:0] only for byte stores)
//   busy_out        : high whenever not in IDLE
//   done_out        : completion pulse
//   rdata_out       : load result, held until the next load completes
//   mem_addr_out    : data-memory address
//   mem_data_out    : data-memory write data
//   mem_write_out   : data-memory write enable
//   mem_data_in     : data-memory combinational read data
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = mem_access_unit_pkg::ADDR_W,
  parameter int BYTE_W = mem_access_unit_pkg::BYTE_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                req_in,
  input  logic                write_in,
  input  logic                wide_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [2*BYTE_W-1:0] wdata_in,
  output logic                busy_out,
  output logic                done_out,
  output logic [2*BYTE_W-1:0] rdata_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [BYTE_W-1:0]   mem_data_out,
  output logic                mem_write_out,
  input  logic [BYTE_W-1:0]   mem_data_in
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr_q;
  logic [2*BYTE_W-1:0] wdata_q;
  logic                write_q;
  logic                wide_q;
  logic [BYTE_W-1:0]   lo_q;
  logic [2*BYTE_W-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Write enable is gated by RESET so that a reset landing on the closing
  // edge of a memory cycle aborts that write rather than completing it.
  always_comb begin
    state_nxt     = state;
    busy_out      = 1'b1;
    done_out      = 1'b0;
    mem_addr_out  = '0;
    mem_data_out  = '0;
    mem_write_out = 1'b0;
    unique case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (req_in) state_nxt = ACC_LO;
      end
      ACC_LO: begin
        mem_addr_out = addr_q;
        if (write_q) begin
          mem_data_out  = wdata_q[BYTE_W-1:0];
          mem_write_out = ~RESET;
        end
        state_nxt = wide_q ? ACC_HI : DONE;
      end
      ACC_HI: begin
        mem_addr_out = addr_q + 1'b1;
        if (write_q) begin
          mem_data_out  = wdata_q[2*BYTE_W-1:BYTE_W];
          mem_write_out = ~RESET;
        end
        state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The low byte of a wide load is parked in lo_q so rdata_out only changes
  // on entry to DONE and holds the previous result while the load runs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req_in) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        write_q <= write_in;
        wide_q  <= wide_in;
      end
      if (state == ACC_LO && !write_q) begin
        if (wide_q) lo_q    <= mem_data_in;
        else        rdata_q <= {{BYTE_W{1'b0}}, mem_data_in};
      end
      if (state == ACC_HI && !write_q) begin
        rdata_q <= {mem_data_in, lo_q};
      end
    end
  end

  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit paired with a 256-byte data memory.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_in, write_in, wide_in;
  logic [7:0]  addr_in;
  logic [15:0] wdata_in;
  logic        busy_out, done_out, mem_write_out;
  logic [15:0] rdata_out;
  logic [7:0]  mem_addr_out, mem_data_out, mem_data_in;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] ref_rdata;
  logic        init_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(8), .BYTE_W(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .req_in        (req_in),
    .write_in      (write_in),
    .wide_in       (wide_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .rdata_out     (rdata_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .mem_write_out (mem_write_out),
    .mem_data_in   (mem_data_in)
  );

  function automatic logic [7:0] init_byte(input int i);
    if (i == 5) return 8'h9C;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Data memory: combinational read, write on posedge.
  always @(posedge CLK) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (mem_write_out) begin
      mem[mem_addr_out] <= mem_data_out;
    end
  end
  assign mem_data_in = mem[mem_addr_out];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with the reference model applied up front.
  task automatic do_txn(input logic wr, input logic wd, input logic [7:0] a, input logic [15:0] d);
    logic [7:0] ah;
    int cyc, wcnt;
    logic got;
    ah = a + 8'd1;
    if (wr) begin
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[ah] = d[15:8];
    end else begin
      ref_rdata = wd ? {ref_mem[ah], ref_mem[a]} : {8'h00, ref_mem[a]};
    end

    @(negedge CLK);
    req_in = 1'b1; write_in = wr; wide_in = wd; addr_in = a; wdata_in = d;
    @(posedge CLK); #1;
    // Junk on the request inputs while busy must be ignored.
    req_in = 1'($urandom); write_in = 1'($urandom); wide_in = 1'($urandom);
    addr_in = 8'($urandom); wdata_in = 16'($urandom);
    cyc = 0; wcnt = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      cyc++;
      if (mem_write_out) begin
        check("wr_addr", mem_addr_out, (wcnt == 0) ? a : ah);
        check("wr_data", mem_data_out, (wcnt == 0) ? d[7:0] : d[15:8]);
        wcnt++;
      end
      if (done_out) got = 1'b1;
      else begin
        @(posedge CLK); #1;
      end
    end
    req_in = 1'b0;
    check("done_seen", got, 1'b1);
    check("latency", cyc, wd ? 3 : 2);
    check("write_cycles", wcnt, wr ? (wd ? 2 : 1) : 0);
    check("done_addr0", mem_addr_out, 8'h00);
    check("done_data0", mem_data_out, 8'h00);
    check("rdata", rdata_out, ref_rdata);
    @(posedge CLK); #1;
    check("done_pulse", done_out, 1'b0);
    check("idle_busy", busy_out, 1'b0);
    check("rdata_hold", rdata_out, ref_rdata);
    check("mem_lo", mem[a], ref_mem[a]);
    check("mem_hi", mem[ah], ref_mem[ah]);
  endtask

  initial begin
    logic busy_s [6];
    logic done_s [6];
    logic [7:0] wr_a [4];
    logic [7:0] wr_d [4];
    int wn;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    ref_rdata = 16'h0000;
    init_en = 1'b1;
    RESET = 1'b1;
    req_in = 1'b1; write_in = 1'b1; wide_in = 1'b1;
    addr_in = 8'h33; wdata_in = 16'h5555;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_rdata", rdata_out, 16'h0000);
    check("rst_wr", mem_write_out, 1'b0);
    check("rst_addr", mem_addr_out, 8'h00);
    check("rst_data", mem_data_out, 8'h00);
    @(negedge CLK);
    RESET = 1'b0; init_en = 1'b0; req_in = 1'b0;

    // Directed cases.
    do_txn(1'b1, 1'b0, 8'h10, 16'h0021);
    do_txn(1'b1, 1'b1, 8'h2A, 16'hBEEF);
    do_txn(1'b0, 1'b1, 8'h2A, 16'h0000);
    do_txn(1'b1, 1'b1, 8'hFF, 16'h1234);
    check("wrap_ff", mem[8'hFF], 8'h34);
    check("wrap_00", mem[8'h00], 8'h12);
    do_txn(1'b0, 1'b0, 8'h05, 16'hFFFF);
    check("byte_load_9c", rdata_out, 16'h009C);
    do_txn(1'b1, 1'b0, 8'h2A, 16'h7777);
    check("store_keeps_rdata", rdata_out, 16'h009C);

    // req_in held high across two byte stores.
    @(negedge CLK);
    req_in = 1'b1; write_in = 1'b1; wide_in = 1'b0; addr_in = 8'h60; wdata_in = 16'h0011;
    wn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      busy_s[i] = busy_out;
      done_s[i] = done_out;
      if (mem_write_out && wn < 4) begin
        wr_a[wn] = mem_addr_out;
        wr_d[wn] = mem_data_out;
        wn++;
      end
      if (i == 1) begin
        addr_in = 8'h61; wdata_in = 16'h0022;
      end
    end
    req_in = 1'b0;
    check("b2b_busy", {busy_s[0], busy_s[1], busy_s[2], busy_s[3], busy_s[4], busy_s[5]}, 6'b110110);
    check("b2b_done", {done_s[0], done_s[1], done_s[2], done_s[3], done_s[4], done_s[5]}, 6'b010010);
    check("b2b_nwr", wn, 2);
    check("b2b_a0", wr_a[0], 8'h60);
    check("b2b_d0", wr_d[0], 8'h11);
    check("b2b_a1", wr_a[1], 8'h61);
    check("b2b_d1", wr_d[1], 8'h22);
    ref_mem[8'h60] = 8'h11;
    ref_mem[8'h61] = 8'h22;
    check("b2b_m60", mem[8'h60], 8'h11);
    check("b2b_m61", mem[8'h61], 8'h22);

    // Reset during ACC_HI of a wide store.
    @(negedge CLK);
    req_in = 1'b1; write_in = 1'b1; wide_in = 1'b1; addr_in = 8'h40; wdata_in = 16'hAAAA;
    @(posedge CLK); #1;
    req_in = 1'b0;
    @(posedge CLK); #1;
    check("abort_hi_addr", mem_addr_out, 8'h41);
    check("abort_hi_wr", mem_write_out, 1'b1);
    RESET = 1'b1;
    #1;
    check("abort_wr_gated", mem_write_out, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    ref_mem[8'h40] = 8'hAA;
    ref_rdata = 16'h0000;
    check("abort_busy", busy_out, 1'b0);
    check("abort_done", done_out, 1'b0);
    check("abort_rdata", rdata_out, 16'h0000);
    check("abort_wr", mem_write_out, 1'b0);
    check("abort_addr", mem_addr_out, 8'h00);
    check("abort_data", mem_data_out, 8'h00);
    check("abort_m40", mem[8'h40], 8'hAA);
    check("abort_m41", mem[8'h41], ref_mem[8'h41]);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("abort_no_done", done_out, 1'b0);
    end

    // Randomized traffic, biased toward the wrap address.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      do_txn(1'($urandom), 1'($urandom), ra, 16'($urandom));
    end

    // Final full memory sweep against the model.
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) check("mem_sweep", mem[i], ref_mem[i]);
    end
    check("mem_sweep_00", mem[0], ref_mem[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the data-memory address width in bits.
REQ-002 The block SHALL have parameter BYTE_W, default 8, meaning the data-memory word width in bits.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on posedge.
REQ-004 The block SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_in  input  1  access request from datapath, sampled only in IDLE.
REQ-006 The block SHALL have port write_in  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port wide_in  input  1  1 = 16-bit access (two bytes), 0 = 8-bit access.
REQ-008 The block SHALL have port addr_in  input  8  base byte address.
REQ-009 The block SHALL have port wdata_in  input  16  store data; only [7:0] is used when wide_in=0.
REQ-010 The block SHALL have port busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port rdata_out  output  16  load result.
REQ-013 The block SHALL have port mem_addr_out  output  8  address to the data memory.
REQ-014 The block SHALL have port mem_data_out  output  8  write data to the data memory.
REQ-015 The block SHALL have port mem_write_out  output  1  write enable to the data memory.
REQ-016 The block SHALL have port mem_data_in  input  8  combinational read data from the data memory.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ACC_LO, ACC_HI and DONE.
REQ-018 In IDLE, when req_in=1 at a posedge, the block SHALL latch addr_in, wdata_in, write_in and wide_in and go to ACC_LO.
REQ-019 When not in IDLE, the block SHALL ignore req_in; no requests are queued.
REQ-020 In ACC_LO, the block SHALL drive mem_addr_out=addr and, for a store, mem_data_out=wdata[7:0] with mem_write_out=1.
REQ-021 In ACC_LO for a load, the block SHALL capture mem_data_in into rdata[7:0] at the closing edge.
REQ-022 From ACC_LO, the FSM SHALL go to ACC_HI if wide=1, otherwise to DONE.
REQ-023 In ACC_HI, the block SHALL drive mem_addr_out=(addr+1) mod 256, with wrap from 0xFF to 0x00; a store uses wdata[15:8] and a load captures into rdata[15:8].
REQ-024 Data SHALL be little-endian: the low byte is at addr and the high byte is at addr+1.
REQ-025 In DONE, the block SHALL assert done_out=1 for exactly one cycle and then return to IDLE.
REQ-026 rdata_out SHALL be valid from DONE onward and hold until the next load reaches DONE; stores SHALL NOT alter it.
REQ-027 A byte load SHALL zero-extend: rdata_out[15:8]=0.
REQ-028 mem_write_out SHALL be 0 in IDLE, in DONE, and for every load.
REQ-029 In IDLE and DONE, mem_addr_out SHALL be 0 and mem_data_out SHALL be 0.
REQ-030 Latency from the accepting edge to done_out high SHALL be 2 cycles for a byte access and 3 cycles for a wide access.
REQ-031 Back-to-back: the next request SHALL be accepted no earlier than the first IDLE cycle after DONE.

Reset
REQ-032 When RESET=1 at a posedge, the block SHALL set state=IDLE, busy_out=0, done_out=0, rdata_out=0, mem_write_out=0, mem_addr_out=0 and mem_data_out=0.
REQ-033 RESET SHALL take priority over req_in.
REQ-034 RESET asserted mid-operation SHALL abort the operation: no further memory writes, no done_out, and a low byte already written remains in memory.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ACC_LO, ACC_HI, DONE) and the ADDR_W and BYTE_W constants.
REQ-036 The block SHALL be a single module with no sub-modules; a bench instance SHALL pair it with the data memory at top level.

Verification
REQ-037 Byte store: addr=0x10, wdata=0x0021, wide=0 -> mem_write_out high for exactly 1 cycle at addr 0x10 with data 0x21, and done_out 2 cycles after accept.
REQ-038 Wide load after wide store 0xBEEF to 0x2A -> M[0x2A]=0xEF, M[0x2B]=0xBE, and the load returns rdata_out=0xBEEF 3 cycles after accept.
REQ-039 Wrap-around: wide store 0x1234 at 0xFF -> M[0xFF]=0x34 and M[0x00]=0x12.
REQ-040 Byte load of M[0x05]=0x9C -> rdata_out=0x009C and mem_write_out stays 0 throughout.
REQ-041 req_in held high continuously across two transactions -> the second is accepted only in the IDLE cycle after DONE, with busy_out low for exactly that cycle.
REQ-042 RESET asserted during ACC_HI of a wide store 0xAAAA to 0x40 -> M[0x40]=0xAA, M[0x41] unchanged, no done_out, and all outputs 0 on the next cycle.
